// File: rtl/deconv_pkg.sv
// deconv_pkg
//   Shared definitions for the multi-channel transposed-convolution engine:
//   data widths, the control state encoding, result-RAM geometry helpers
//   and the product-to-accumulator sign extension.
package deconv_pkg;

    localparam int PIXEL_BITS = 8;
    localparam int ACC_BITS   = 24;
    localparam int PROD_BITS  = 2 * PIXEL_BITS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD_W,
        ST_WAIT_PX,
        ST_ACCUM,
        ST_DONE
    } state_t;

    // Row pitch of the result RAM: the largest output map any legal
    // kernel width / stride pair can produce.
    function automatic int calc_out_max(input int n, input int k_max);
        return n * k_max;
    endfunction

    function automatic int calc_depth(input int n, input int k_max);
        return calc_out_max(n, k_max) * calc_out_max(n, k_max);
    endfunction

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    // A signed cast to the wider type replicates the product's sign bit.
    function automatic logic signed [ACC_BITS-1:0] sext_acc(input logic signed [PROD_BITS-1:0] p);
        return ACC_BITS'(p);
    endfunction

endpackage

// File: rtl/deconv_addr_gen.sv
// deconv_addr_gen
//   Maps an input pixel position and a kernel tap onto the flat result-RAM
//   index it contributes to: (pr*stride + kr) * OUT_MAX + pc*stride + kc.
// Ports:
//   pr, pc  - input pixel row / column
//   kr, kc  - kernel tap row / column
//   stride  - latched job stride
//   addr    - result RAM index
module deconv_addr_gen
    import deconv_pkg::*;
#(
    parameter  int N       = 2,
    parameter  int K_MAX   = 3,
    localparam int OUT_MAX = calc_out_max(N, K_MAX),
    localparam int KW_W    = $clog2(K_MAX + 1),
    localparam int KIDX_W  = idx_width(K_MAX),
    localparam int NIDX_W  = idx_width(N),
    localparam int ADDR_W  = idx_width(calc_depth(N, K_MAX))
) (
    input  logic [NIDX_W-1:0] pr,
    input  logic [NIDX_W-1:0] pc,
    input  logic [KIDX_W-1:0] kr,
    input  logic [KIDX_W-1:0] kc,
    input  logic [KW_W-1:0]   stride,
    output logic [ADDR_W-1:0] addr
);

    int row;
    int col;

    // Legal configurations (stride <= kw <= K_MAX) keep row and col below
    // OUT_MAX, so the truncation to ADDR_W never drops significant bits.
    always_comb begin
        row  = int'(pr) * int'(stride) + int'(kr);
        col  = int'(pc) * int'(stride) + int'(kc);
        addr = ADDR_W'(row * OUT_MAX + col);
    end

endmodule

// File: rtl/deconv2d_mc.sv
// deconv2d_mc
//   Signed multi-channel transposed-convolution engine. A job clears the
//   result RAM, loads C_IN kw x kw kernels, then for each input pixel
//   (channel-major, row-major) forms kw*kw products and scatters them into
//   the result RAM one per cycle.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   start, kw, stride   - job launch and its configuration (sampled in IDLE)
//   w_valid/w_ready/w_data    - weight stream
//   px_valid/px_ready/px_data - pixel stream
//   busy, done, cfg_err - job status
//   out_dim             - output map width/height of the current job
//   rd_addr, rd_data    - result readout, one cycle latency
module deconv2d_mc
    import deconv_pkg::*;
#(
    parameter  int N       = 2,
    parameter  int K_MAX   = 3,
    parameter  int C_IN    = 2,
    localparam int OUT_MAX = calc_out_max(N, K_MAX),
    localparam int DEPTH   = calc_depth(N, K_MAX),
    localparam int KW_W    = $clog2(K_MAX + 1),
    localparam int DIM_W   = $clog2(OUT_MAX + 1),
    localparam int ADDR_W  = idx_width(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [KW_W-1:0]              kw,
    input  logic [KW_W-1:0]              stride,
    input  logic                         w_valid,
    output logic                         w_ready,
    input  logic signed [PIXEL_BITS-1:0] w_data,
    input  logic                         px_valid,
    output logic                         px_ready,
    input  logic signed [PIXEL_BITS-1:0] px_data,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_err,
    output logic [DIM_W-1:0]             out_dim,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic signed [ACC_BITS-1:0]   rd_data
);

    localparam int KK        = K_MAX * K_MAX;
    localparam int KIDX_W    = idx_width(K_MAX);
    localparam int WIDX_W    = idx_width(C_IN * KK);
    localparam int PIDX_W    = idx_width(KK);
    localparam int PIX_TOTAL = N * N * C_IN;
    localparam int PIX_W     = idx_width(PIX_TOTAL);
    localparam int NIDX_W    = idx_width(N);
    localparam int CH_W      = idx_width(C_IN);

    state_t                       state_q, state_d;
    logic [KW_W-1:0]              kw_q, kw_d;
    logic [KW_W-1:0]              stride_q, stride_d;
    logic                         cfg_err_q, cfg_err_d;
    logic [DIM_W-1:0]             out_dim_q, out_dim_d;
    logic [ADDR_W-1:0]            clr_q, clr_d;
    logic [CH_W-1:0]              w_ch_q, w_ch_d;
    logic [KIDX_W-1:0]            w_r_q, w_r_d;
    logic [KIDX_W-1:0]            w_c_q, w_c_d;
    logic [PIX_W-1:0]             pix_q, pix_d;
    logic [KIDX_W-1:0]            kr_q, kr_d;
    logic [KIDX_W-1:0]            kc_q, kc_d;
    logic signed [PROD_BITS-1:0]  prod_q [KK];
    logic signed [PROD_BITS-1:0]  prod_d [KK];
    logic signed [ACC_BITS-1:0]   rd_data_q, rd_data_d;

    logic signed [PIXEL_BITS-1:0] kernel_ram [C_IN*KK];
    logic signed [ACC_BITS-1:0]   result_ram [DEPTH];

    logic                         cfg_bad, w_hs, px_hs, w_last, acc_last, pix_last;
    logic [CH_W-1:0]              px_ch;
    logic [NIDX_W-1:0]            pr, pc;
    logic [WIDX_W-1:0]            w_idx;
    logic [PIDX_W-1:0]            p_idx;
    logic [ADDR_W-1:0]            acc_addr, ram_waddr;
    logic                         ram_we;
    logic signed [ACC_BITS-1:0]   ram_wdata;

    deconv_addr_gen #(.N(N), .K_MAX(K_MAX)) u_addr_gen (
        .pr     (pr),
        .pc     (pc),
        .kr     (kr_q),
        .kc     (kc_q),
        .stride (stride_q),
        .addr   (acc_addr)
    );

    // Handshakes, end-of-phase flags and the pixel index split into
    // channel / row / column of the current input map.
    always_comb begin
        cfg_bad  = (kw == '0) || (int'(kw) > K_MAX) || (stride == '0) || (stride > kw);
        w_hs     = w_valid && w_ready;
        px_hs    = px_valid && px_ready;
        w_last   = (int'(w_ch_q) == C_IN - 1) && (int'(w_r_q) == int'(kw_q) - 1)
                   && (int'(w_c_q) == int'(kw_q) - 1);
        acc_last = (int'(kr_q) == int'(kw_q) - 1) && (int'(kc_q) == int'(kw_q) - 1);
        pix_last = (int'(pix_q) == PIX_TOTAL - 1);
        px_ch    = CH_W'(int'(pix_q) / (N * N));
        pr       = NIDX_W'((int'(pix_q) % (N * N)) / N);
        pc       = NIDX_W'((int'(pix_q) % (N * N)) % N);
        w_idx    = WIDX_W'(int'(w_ch_q) * KK + int'(w_r_q) * K_MAX + int'(w_c_q));
        p_idx    = PIDX_W'(int'(kr_q) * K_MAX + int'(kc_q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start && !cfg_bad) state_d = ST_CLEAR;
            ST_CLEAR:   if (int'(clr_q) == DEPTH - 1) state_d = ST_LOAD_W;
            ST_LOAD_W:  if (w_hs && w_last) state_d = ST_WAIT_PX;
            ST_WAIT_PX: if (px_hs) state_d = ST_ACCUM;
            ST_ACCUM:   if (acc_last) state_d = pix_last ? ST_DONE : ST_WAIT_PX;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Status and ready outputs decode the state register directly, so an
    // asynchronous reset drops them immediately.
    always_comb begin
        busy     = (state_q != ST_IDLE);
        w_ready  = (state_q == ST_LOAD_W);
        px_ready = (state_q == ST_WAIT_PX);
        done     = (state_q == ST_DONE);
    end

    // Datapath next-state. The single result-RAM write port is shared by the
    // clear sweep and the read-modify-write accumulation.
    always_comb begin
        kw_d      = kw_q;
        stride_d  = stride_q;
        cfg_err_d = cfg_err_q;
        out_dim_d = out_dim_q;
        clr_d     = clr_q;
        w_ch_d    = w_ch_q;
        w_r_d     = w_r_q;
        w_c_d     = w_c_q;
        pix_d     = pix_q;
        kr_d      = kr_q;
        kc_d      = kc_q;
        prod_d    = prod_q;
        ram_we    = 1'b0;
        ram_waddr = acc_addr;
        ram_wdata = result_ram[acc_addr] + sext_acc(prod_q[p_idx]);
        rd_data_d = result_ram[rd_addr];
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    kw_d      = kw;
                    stride_d  = stride;
                    cfg_err_d = cfg_bad;
                    out_dim_d = DIM_W'((N - 1) * int'(stride) + int'(kw));
                    clr_d     = '0;
                    w_ch_d    = '0;
                    w_r_d     = '0;
                    w_c_d     = '0;
                    pix_d     = '0;
                    kr_d      = '0;
                    kc_d      = '0;
                end
            end
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_q;
                ram_wdata = '0;
                clr_d     = clr_q + 1'b1;
            end
            ST_LOAD_W: begin
                if (w_hs) begin
                    if (int'(w_c_q) == int'(kw_q) - 1) begin
                        w_c_d = '0;
                        if (int'(w_r_q) == int'(kw_q) - 1) begin
                            w_r_d  = '0;
                            w_ch_d = w_ch_q + 1'b1;
                        end else begin
                            w_r_d = w_r_q + 1'b1;
                        end
                    end else begin
                        w_c_d = w_c_q + 1'b1;
                    end
                end
            end
            ST_WAIT_PX: begin
                if (px_hs) begin
                    // All K_MAX*K_MAX slots are filled; only the kw x kw
                    // corner is ever consumed.
                    for (int i = 0; i < KK; i++) begin
                        prod_d[i] = PROD_BITS'(px_data)
                                  * PROD_BITS'(kernel_ram[WIDX_W'(int'(px_ch) * KK + i)]);
                    end
                    kr_d = '0;
                    kc_d = '0;
                end
            end
            ST_ACCUM: begin
                ram_we = 1'b1;
                if (int'(kc_q) == int'(kw_q) - 1) begin
                    kc_d = '0;
                    kr_d = acc_last ? '0 : kr_q + 1'b1;
                end else begin
                    kc_d = kc_q + 1'b1;
                end
                if (acc_last && !pix_last) pix_d = pix_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kw_q      <= '0;
            stride_q  <= '0;
            cfg_err_q <= 1'b0;
            out_dim_q <= '0;
            clr_q     <= '0;
            w_ch_q    <= '0;
            w_r_q     <= '0;
            w_c_q     <= '0;
            pix_q     <= '0;
            kr_q      <= '0;
            kc_q      <= '0;
            prod_q    <= '{default: '0};
            rd_data_q <= '0;
        end else begin
            kw_q      <= kw_d;
            stride_q  <= stride_d;
            cfg_err_q <= cfg_err_d;
            out_dim_q <= out_dim_d;
            clr_q     <= clr_d;
            w_ch_q    <= w_ch_d;
            w_r_q     <= w_r_d;
            w_c_q     <= w_c_d;
            pix_q     <= pix_d;
            kr_q      <= kr_d;
            kc_q      <= kc_d;
            prod_q    <= prod_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage arrays carry no reset; the CLEAR sweep initialises results.
    always_ff @(posedge clk) begin
        if (state_q == ST_LOAD_W && w_hs) kernel_ram[w_idx] <= w_data;
        if (ram_we) result_ram[ram_waddr] <= ram_wdata;
    end

    assign cfg_err = cfg_err_q;
    assign out_dim = out_dim_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_deconv2d_mc.sv
// tb_deconv2d_mc
//   Directed bench for deconv2d_mc (N=2, K_MAX=3, C_IN=2). Expected result
//   maps come from a direct scatter-add model of transposed convolution.
module tb_deconv2d_mc;

    localparam int N       = 2;
    localparam int K_MAX   = 3;
    localparam int C_IN    = 2;
    localparam int OUT_MAX = N * K_MAX;
    localparam int DEPTH   = OUT_MAX * OUT_MAX;
    localparam int KW_W    = 2;
    localparam int TIMEOUT = 2000;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [KW_W-1:0]   kw, stride;
    logic              w_valid, w_ready;
    logic signed [7:0] w_data;
    logic              px_valid, px_ready;
    logic signed [7:0] px_data;
    logic              busy, done, cfg_err;
    logic [2:0]        out_dim;
    logic [5:0]        rd_addr;
    logic signed [23:0] rd_data;

    always #5 clk = ~clk;

    deconv2d_mc #(.N(N), .K_MAX(K_MAX), .C_IN(C_IN)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .kw       (kw),
        .stride   (stride),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_data   (w_data),
        .px_valid (px_valid),
        .px_ready (px_ready),
        .px_data  (px_data),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfg_err),
        .out_dim  (out_dim),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int wts [C_IN*K_MAX*K_MAX];
    int pxs [C_IN*N*N];
    int exp_map [DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, required);
        end
    endtask

    function automatic int wrap24(input int v);
        logic signed [23:0] t;
        t = 24'(v);
        return int'(t);
    endfunction

    // Scatter-add every pixel times every kernel tap into the output map.
    task automatic buildModel(input int k, input int s);
        foreach (exp_map[a]) exp_map[a] = 0;
        for (int c = 0; c < C_IN; c++)
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    for (int r = 0; r < k; r++)
                        for (int q = 0; q < k; q++)
                            exp_map[(i*s + r)*OUT_MAX + j*s + q] +=
                                pxs[c*N*N + i*N + j] * wts[c*k*k + r*k + q];
        foreach (exp_map[a]) exp_map[a] = wrap24(exp_map[a]);
    endtask

    task automatic loadScenario(input int id);
        foreach (wts[i]) wts[i] = 0;
        foreach (pxs[i]) pxs[i] = 0;
        case (id)
            1: begin
                for (int i = 0; i < 4; i++) begin wts[i] = 1; pxs[i] = i + 1; end
            end
            2: begin
                for (int i = 0; i < 9; i++) wts[i] = 1;
                for (int i = 0; i < 4; i++) pxs[i] = 1;
            end
            default: begin
                wts[0] = -128;
                wts[1] = 2;
                for (int i = 0; i < 4; i++) begin pxs[i] = -128; pxs[4 + i] = -3; end
            end
        endcase
    endtask

    // Runs one job. gaps inserts random w_valid idle cycles; abort resets
    // the DUT a few cycles into the first ACCUM phase.
    task automatic applyStimulus(input int k, input int s, input bit gaps, input bit abort);
        int  t, lows, hs, bad_px, start_cyc, done_cyc;
        bit  got;
        @(posedge clk); #1;
        kw = KW_W'(k); stride = KW_W'(s); start = 1'b1;
        px_valid = 1'b1; px_data = 8'(pxs[0]);
        @(posedge clk); #1;
        start_cyc = cyc;
        // A second start with another kernel width must be ignored.
        kw = KW_W'(1);
        checkOutput("cfg_err cleared by start", int'(cfg_err), 0);
        checkOutput("busy after start", int'(busy), 1);
        checkOutput("out_dim", int'(out_dim), (N - 1)*s + k);
        @(posedge clk); #1;
        start = 1'b0; kw = KW_W'(k);

        bad_px = 0;
        for (int wi = 0; wi < C_IN*k*k; wi++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                w_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
            w_valid = 1'b1; w_data = 8'(wts[wi]);
            t = 0;
            do begin
                @(negedge clk); got = w_ready; if (px_ready) bad_px++;
                @(posedge clk); #1; t++;
            end while (!got && t < TIMEOUT);
            if (!got) begin checkOutput("weight handshake timeout", 0, 1); return; end
        end
        w_valid = 1'b0;
        checkOutput("px_ready during LOAD_W", bad_px, 0);

        hs = 0;
        for (int pi = 0; pi < C_IN*N*N; pi++) begin
            px_data = 8'(pxs[pi]); lows = 0; t = 0;
            do begin
                @(negedge clk); got = px_ready; if (!got) lows++;
                @(posedge clk); #1; t++;
            end while (!got && t < TIMEOUT);
            if (!got) begin checkOutput("pixel handshake timeout", 0, 1); return; end
            hs++;
            if (pi > 0) checkOutput($sformatf("px_ready low run %0d", pi), lows, k*k);
            if (abort) begin
                repeat (2) @(posedge clk);
                #2;
                checkOutput("busy before abort", int'(busy), 1);
                rst = 1'b1;
                #1;
                checkOutput("busy async reset", int'(busy), 0);
                checkOutput("done async reset", int'(done), 0);
                checkOutput("px_ready async reset", int'(px_ready), 0);
                @(posedge clk); #1;
                rst = 1'b0; px_valid = 1'b0;
                return;
            end
        end
        px_valid = 1'b0;
        checkOutput("pixel handshakes", hs, C_IN*N*N);

        t = 0;
        do begin @(negedge clk); got = done; t++; end while (!got && t < TIMEOUT);
        if (!got) begin checkOutput("done timeout", 0, 1); return; end
        done_cyc = cyc;
        if (!gaps)
            checkOutput("latency", done_cyc - start_cyc + 1,
                        DEPTH + C_IN*k*k + C_IN*N*N*(1 + k*k) + 1);
        @(negedge clk);
        checkOutput("done single pulse", int'(done), 0);
        checkOutput("idle after done", int'(busy), 0);
    endtask

    task automatic readAddr(input int a, output int v);
        @(posedge clk); #1;
        rd_addr = 6'(a);
        @(posedge clk); #1;
        v = int'(rd_data);
    endtask

    task automatic checkMap(input string name);
        int v;
        for (int a = 0; a < DEPTH; a++) begin
            readAddr(a, v);
            checkOutput($sformatf("%s rd[%0d]", name, a), v, exp_map[a]);
        end
    endtask

    task automatic checkLiteral(input string name, input int row, input int col, input int lit);
        int v;
        readAddr(row*OUT_MAX + col, v);
        checkOutput(name, v, lit);
    endtask

    task automatic cfgError(input int k, input int s, input string name);
        int bad;
        @(posedge clk); #1;
        kw = KW_W'(k); stride = KW_W'(s); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput({name, " cfg_err"}, int'(cfg_err), 1);
        bad = 0;
        repeat (4) begin @(negedge clk); if (w_ready || busy) bad++; end
        checkOutput({name, " stays idle"}, bad, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; kw = '0; stride = '0;
        w_valid = 1'b0; w_data = '0; px_valid = 1'b0; px_data = '0; rd_addr = '0;
        repeat (2) @(posedge clk); #1;
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset cfg_err", int'(cfg_err), 0);
        checkOutput("reset w_ready", int'(w_ready), 0);
        checkOutput("reset px_ready", int'(px_ready), 0);
        checkOutput("reset out_dim", int'(out_dim), 0);
        checkOutput("reset rd_data", int'(rd_data), 0);
        rst = 1'b0;

        $display("[TB] kw=2 stride=2 quadrant test");
        loadScenario(1); buildModel(2, 2);
        applyStimulus(2, 2, 1'b0, 1'b0);
        checkMap("s1");
        checkLiteral("s1 (0,0)", 0, 0, 1);
        checkLiteral("s1 (1,3)", 1, 3, 2);
        checkLiteral("s1 (3,3)", 3, 3, 4);

        $display("[TB] kw=3 stride=1 overlap test");
        loadScenario(2); buildModel(3, 1);
        applyStimulus(3, 1, 1'b0, 1'b0);
        checkMap("s2");
        checkLiteral("s2 (0,0)", 0, 0, 1);
        checkLiteral("s2 (0,1)", 0, 1, 2);
        checkLiteral("s2 (1,1)", 1, 1, 4);
        checkLiteral("s2 (3,3)", 3, 3, 1);

        $display("[TB] signed multi-channel test");
        loadScenario(3); buildModel(1, 1);
        applyStimulus(1, 1, 1'b0, 1'b0);
        checkMap("s3");
        checkLiteral("s3 (0,0)", 0, 0, 16378);
        checkLiteral("s3 (1,1)", 1, 1, 16378);
        checkLiteral("s3 (0,2)", 0, 2, 0);

        $display("[TB] configuration errors");
        cfgError(2, 0, "stride0");
        // kw=4 does not fit the 2-bit port and arrives as 0.
        cfgError(KW_W'(4), 1, "kw4");

        $display("[TB] weight gaps, kw=3");
        loadScenario(2); buildModel(3, 1);
        applyStimulus(3, 1, 1'b1, 1'b0);
        checkMap("gaps");

        $display("[TB] reset mid-ACCUM then rerun");
        applyStimulus(3, 1, 1'b0, 1'b1);
        applyStimulus(3, 1, 1'b0, 1'b0);
        checkMap("rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
